// File: rtl/fetch_pipeline_ctrl.sv
// Fetch-stage sequencing controller: reset hold-off, branch redirect/flush,
// load-use stall and HLT arbitration for the PC and IF/OF latch controls.
module fetch_pipeline_ctrl #(
    parameter int unsigned RESET_HOLD   = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_req,
    input  logic             branch_taken,
    input  logic [31:0]      branch_pc,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_write_en,
    output logic             pc_load_branch,
    output logic [31:0]      pc_target,
    output logic             if_of_enable,
    output logic             if_of_bubble,
    output logic             of_ex_flush,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned SEQ_W      = $clog2(RESET_HOLD + FLUSH_CYCLES + 1);
    localparam int unsigned FLUSH_LAST = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_HALT  = 3'd3
    } state_t;

    state_t           r_state;
    logic [SEQ_W-1:0] r_seq_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic             w_redirect;
    state_t           w_redirect_state;

    // Branch accepted in every post-reset state; the older EX instruction beats OF requests
    assign w_redirect       = branch_taken && (r_state != S_INIT);
    assign w_redirect_state = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_INIT;
            r_seq_cnt      <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_seq_cnt == SEQ_W'(RESET_HOLD - 1)) begin
                        r_state   <= S_RUN;
                        r_seq_cnt <= '0;
                    end else begin
                        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_redirect) begin
                        r_state       <= w_redirect_state;
                        r_seq_cnt     <= '0;
                        r_flush_count <= r_flush_count + CNT_W'(1);
                    end else if (halt_req) begin
                        r_state <= S_HALT;
                    end else if (stall_req) begin
                        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (w_redirect) begin
                        r_seq_cnt     <= '0;
                        r_flush_count <= r_flush_count + CNT_W'(1);
                    end else if (r_seq_cnt == SEQ_W'(FLUSH_LAST)) begin
                        r_state   <= S_RUN;
                        r_seq_cnt <= '0;
                    end else begin
                        r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
                    end
                end
                S_HALT: begin
                    if (w_redirect) begin
                        r_state       <= w_redirect_state;
                        r_seq_cnt     <= '0;
                        r_flush_count <= r_flush_count + CNT_W'(1);
                    end else if (resume) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state   <= S_INIT;
                    r_seq_cnt <= '0;
                end
            endcase
        end
    end

    // Control strobes decoded from current state and inputs, forced quiet during reset
    always_comb begin
        pc_write_en    = 1'b0;
        pc_load_branch = 1'b0;
        pc_target      = 32'h0;
        if_of_enable   = 1'b0;
        if_of_bubble   = 1'b0;
        of_ex_flush    = 1'b0;
        if (!rst) begin
            if (w_redirect) begin
                pc_write_en    = 1'b1;
                pc_load_branch = 1'b1;
                pc_target      = branch_pc;
                if_of_enable   = 1'b1;
                if_of_bubble   = 1'b1;
                of_ex_flush    = 1'b1;
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (halt_req) begin
                            pc_write_en = 1'b0;
                        end else if (stall_req) begin
                            of_ex_flush = 1'b1;
                        end else begin
                            pc_write_en  = 1'b1;
                            if_of_enable = 1'b1;
                        end
                    end
                    S_FLUSH: begin
                        pc_write_en  = 1'b1;
                        if_of_enable = 1'b1;
                        if_of_bubble = 1'b1;
                    end
                    default: begin
                        pc_write_en = 1'b0;
                    end
                endcase
            end
        end
    end

    assign state        = 3'(r_state);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
